// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
// Credit values are expressed in 5c units throughout.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_VEND,
        ST_CHANGE
    } state_t;

    typedef enum logic [1:0] {
        ACC_HOLD,
        ACC_ADD,
        ACC_VEND,
        ACC_DEC
    } acc_op_t;

    localparam logic [1:0] COIN5_U  = 2'd1;
    localparam logic [1:0] COIN10_U = 2'd2;

    localparam int DEF_CREDIT_W   = 6;
    localparam int DEF_MAX_CREDIT = 20;

    function automatic logic [1:0] coin_units(input logic c5, input logic c10);
        return (c5 ? COIN5_U : 2'd0) + (c10 ? COIN10_U : 2'd0);
    endfunction

endpackage

// File: rtl/vend_txn_ctrl_if.sv
// Dispense and change-hopper handshakes between controller and actuators.
// Controller drives requests; actuators drive acknowledges.
interface vend_txn_ctrl_if #(
    parameter int ID_W = 2
);
    logic            vend_req;
    logic [ID_W-1:0] vend_id;
    logic            vend_ack;
    logic            chg_req;
    logic            chg_ack;

    modport master (
        output vend_req, vend_id, chg_req,
        input  vend_ack, chg_ack
    );

    modport slave (
        input  vend_req, vend_id, chg_req,
        output vend_ack, chg_ack
    );
endinterface

// File: rtl/vend_credit_acc.sv
// Credit register with overflow-checked add, price subtract and decrement.
// The sum is one bit wider than credit so the overflow compare cannot wrap.
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  acc_op_t             op,
    input  logic [1:0]          add,
    input  logic [CREDIT_W-1:0] price,
    output logic [CREDIT_W-1:0] credit,
    output logic                ovf
);

    logic [CREDIT_W:0] sum;

    assign sum = {1'b0, credit} + (CREDIT_W+1)'(add);
    assign ovf = sum > (CREDIT_W+1)'(MAX_CREDIT);

    // Credit register; an overflowing add is dropped whole
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
        end else begin
            unique case (op)
                ACC_ADD:  if (!ovf) credit <= sum[CREDIT_W-1:0];
                ACC_VEND: credit <= credit - price + CREDIT_W'(add);
                ACC_DEC:  credit <= credit - CREDIT_W'(1);
                default:  credit <= credit;
            endcase
        end
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: credit, selection check, dispense
// handshake and one-coin-at-a-time change return.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT,
    parameter int NUM_ITEMS  = 4,
    parameter int ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          coin_5,
    input  logic                          coin_10,
    input  logic                          sel_valid,
    input  logic [ID_W-1:0]               sel_id,
    input  logic                          cancel,
    input  logic [NUM_ITEMS*CREDIT_W-1:0] price_tbl,
    vend_txn_ctrl_if.master               bus,
    output logic [CREDIT_W-1:0]           credit,
    output logic                          busy,
    output logic                          coin_reject,
    output logic                          sel_nak
);

    if (MAX_CREDIT >= 2**CREDIT_W - 2) begin : g_bad_max
        $error("MAX_CREDIT too large for CREDIT_W");
    end
    if (2**ID_W < NUM_ITEMS) begin : g_bad_id
        $error("ID_W too narrow for NUM_ITEMS");
    end

    state_t              state, state_n;
    acc_op_t             op;
    logic [1:0]          add;
    logic                coin, ovf, id_ok, vid_ld;
    logic                rej_n, nak_n;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0] prices [2**ID_W];
    logic [ID_W-1:0]     vid_q;

    for (genvar g = 0; g < 2**ID_W; g++) begin : g_price
        if (g < NUM_ITEMS) begin : g_used
            assign prices[g] = price_tbl[g*CREDIT_W +: CREDIT_W];
        end else begin : g_unused
            assign prices[g] = '0;
        end
    end

    assign add   = coin_units(coin_5, coin_10);
    assign coin  = add != 2'd0;
    assign price = prices[sel_id];
    assign id_ok = {1'b0, sel_id} < (ID_W+1)'(NUM_ITEMS);

    vend_credit_acc #(
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .op     (op),
        .add    (add),
        .price  (price),
        .credit (credit),
        .ovf    (ovf)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next state, credit operation and pulse requests
    always_comb begin
        state_n = state;
        op      = ACC_HOLD;
        rej_n   = 1'b0;
        nak_n   = 1'b0;
        vid_ld  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                nak_n = sel_valid;
                if (coin) begin
                    op      = ACC_ADD;
                    state_n = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (cancel) begin
                    op      = ACC_ADD;
                    rej_n   = coin && ovf;
                    state_n = ST_CHANGE;
                end else if (sel_valid && id_ok && price <= credit) begin
                    op      = ACC_VEND;
                    vid_ld  = 1'b1;
                    state_n = ST_VEND;
                end else begin
                    nak_n = sel_valid;
                    op    = ACC_ADD;
                    rej_n = coin && ovf;
                end
            end
            ST_VEND: begin
                rej_n = coin;
                nak_n = sel_valid;
                if (bus.vend_ack) begin
                    state_n = (credit != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                rej_n = coin;
                nak_n = sel_valid;
                if (bus.chg_ack) begin
                    op = ACC_DEC;
                    if (credit == CREDIT_W'(1)) state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Registered one-cycle pulses and latched item index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coin_reject <= 1'b0;
            sel_nak     <= 1'b0;
            vid_q       <= '0;
        end else begin
            coin_reject <= rej_n;
            sel_nak     <= nak_n;
            if (vid_ld) vid_q <= sel_id;
        end
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        bus.vend_req = state == ST_VEND;
        bus.chg_req  = state == ST_CHANGE;
        bus.vend_id  = vid_q;
        busy         = (state == ST_VEND) || (state == ST_CHANGE);
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Testbench for vend_txn_ctrl: directed scenarios plus random traffic,
// all checked against a credit-and-phase reference model.
module tb_vend_txn_ctrl;

    localparam int CW  = 6;
    localparam int MAX = 20;
    localparam int NI  = 3;
    localparam int IW  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          coin_5 = 1'b0, coin_10 = 1'b0;
    logic          sel_valid = 1'b0, cancel = 1'b0;
    logic [IW-1:0] sel_id = '0;
    logic [NI*CW-1:0] price_tbl;
    logic [CW-1:0] credit;
    logic          busy, coin_reject, sel_nak;

    vend_txn_ctrl_if #(.ID_W(IW)) bus ();

    vend_txn_ctrl #(
        .CREDIT_W(CW), .MAX_CREDIT(MAX), .NUM_ITEMS(NI), .ID_W(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_5(coin_5), .coin_10(coin_10),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
        .price_tbl(price_tbl), .bus(bus.master),
        .credit(credit), .busy(busy),
        .coin_reject(coin_reject), .sel_nak(sel_nak)
    );

    always #5 clk = ~clk;

    int pr [NI] = '{3, 5, 0};
    int n_cmp = 0;
    int n_bad = 0;

    // reference model: credit amount plus "dispensing" / "refunding" phase
    int m_cr;
    bit m_vend, m_chg, m_rej, m_nak;
    int m_vid;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cr = 0; m_vend = 0; m_chg = 0; m_rej = 0; m_nak = 0; m_vid = 0;
    endtask

    task automatic m_coin(input int add);
        if (add > 0) begin
            if (m_cr + add <= MAX) m_cr += add;
            else m_rej = 1;
        end
    endtask

    task automatic m_step(input bit c5, c10, sv, input int id,
                          input bit cn, va, ca);
        int add;
        add = (c5 ? 1 : 0) + (c10 ? 2 : 0);
        m_rej = 0;
        m_nak = 0;
        if (m_vend) begin
            m_rej = add > 0;
            m_nak = sv;
            if (va) begin
                m_vend = 0;
                m_chg  = m_cr > 0;
            end
        end else if (m_chg) begin
            m_rej = add > 0;
            m_nak = sv;
            if (ca) begin
                m_cr--;
                if (m_cr == 0) m_chg = 0;
            end
        end else if (cn && m_cr > 0) begin
            m_coin(add);
            m_chg = 1;
        end else if (sv && m_cr > 0 && id < NI && pr[id] <= m_cr) begin
            m_cr   = m_cr - pr[id] + add;
            m_vid  = id;
            m_vend = 1;
        end else begin
            m_nak = sv;
            m_coin(add);
        end
    endtask

    task automatic cyc(input bit c5, c10, sv, input int id,
                       input bit cn, va, ca);
        coin_5 = c5; coin_10 = c10; sel_valid = sv;
        sel_id = IW'(id); cancel = cn;
        bus.vend_ack = va; bus.chg_ack = ca;
        @(posedge clk);
        m_step(c5, c10, sv, id, cn, va, ca);
        #1;
        check("credit", int'(credit), m_cr);
        check("vend_req", int'(bus.vend_req), int'(m_vend));
        check("chg_req", int'(bus.chg_req), int'(m_chg));
        check("busy", int'(busy), int'(m_vend | m_chg));
        check("coin_reject", int'(coin_reject), int'(m_rej));
        check("sel_nak", int'(sel_nak), int'(m_nak));
        if (m_vend) check("vend_id", int'(bus.vend_id), m_vid);
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (m_vend || m_chg); i++)
            cyc(0, 0, 0, 0, 0, 1, 1);
        check("drain_done", int'(busy), 0);
    endtask

    initial begin
        price_tbl = {6'd0, 6'd5, 6'd3};
        bus.vend_ack = 1'b0;
        bus.chg_ack  = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_credit", int'(credit), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_vend_req", int'(bus.vend_req), 0);
        check("rst_chg_req", int'(bus.chg_req), 0);
        rst_n = 1'b1;
        idle_cyc();

        // basic vend, exact credit
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("basic_credit3", int'(credit), 3);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("basic_vend_req", int'(bus.vend_req), 1);
        check("basic_credit0", int'(credit), 0);
        repeat (3) idle_cyc();
        cyc(0, 0, 0, 0, 0, 1, 0);
        idle_cyc();
        check("basic_no_chg", int'(bus.chg_req), 0);

        // change return with a stalled hopper
        repeat (4) cyc(0, 1, 0, 0, 0, 0, 0);
        check("chg_credit8", int'(credit), 8);
        cyc(0, 0, 1, 1, 0, 0, 0);
        check("chg_credit3", int'(credit), 3);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        repeat (5) idle_cyc();
        check("stall_credit", int'(credit), 2);
        check("stall_chg_req", int'(bus.chg_req), 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("chg_done_credit", int'(credit), 0);
        check("chg_done_busy", int'(busy), 0);

        // overflow
        repeat (9) cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("ovf_reject", int'(coin_reject), 1);
        check("ovf_credit19", int'(credit), 19);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("ovf_credit20", int'(credit), 20);
        cyc(0, 0, 0, 0, 1, 0, 0);
        drain();

        // refusals and cancel with coin
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("nak_price", int'(sel_nak), 1);
        cyc(0, 0, 1, 3, 0, 0, 0);
        check("nak_id", int'(sel_nak), 1);
        cyc(1, 0, 0, 0, 1, 0, 0);
        check("cancel_refund", int'(credit), 3);
        drain();

        // simultaneous events and zero price
        cyc(1, 1, 0, 0, 0, 0, 0);
        check("both_coins", int'(credit), 3);
        cyc(0, 1, 1, 0, 0, 0, 0);
        check("sel_plus_coin", int'(credit), 2);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("vend_coin_rej", int'(coin_reject), 1);
        drain();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 2, 0, 0, 0);
        check("zero_price_vend", int'(bus.vend_req), 1);
        drain();

        // asynchronous reset during change return
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_chg_req", int'(bus.chg_req), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_credit", int'(credit), 0);
        m_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cyc();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_txn_ctrl.md
Name: vend_txn_ctrl

Overview:
- Transaction controller for the coin-operated vending datapath.
- Accumulates credit from 5c/10c coin pulses and checks selections against a configurable price table.
- Sequences a dispense handshake, then returns change one 5c coin at a time over a second handshake.
- Sits between the coin acceptor front end and the dispenser and change-hopper actuators.

Parameters:
- CREDIT_W, 6: width of credit and price fields, in 5c units.
- MAX_CREDIT, 20: maximum accepted credit in 5c units (20 = 100c).
- NUM_ITEMS, 4: number of selectable products.
- ID_W, 2: width of the product index; must satisfy 2**ID_W >= NUM_ITEMS.

Ports:
- clk, in, 1: single system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- coin_5, in, 1: one-cycle pulse, 5c inserted.
- coin_10, in, 1: one-cycle pulse, 10c inserted. Both pulses high in one cycle = 15c.
- sel_valid, in, 1: one-cycle selection strobe.
- sel_id, in, ID_W: product index, valid with sel_valid.
- cancel, in, 1: one-cycle pulse, refund all credit.
- price_tbl, in, NUM_ITEMS*CREDIT_W: item i price at bits [i*CREDIT_W +: CREDIT_W]; quasi-static.
- vend_req, out, 1: dispense request, held until acknowledged.
- vend_id, out, ID_W: item being dispensed, stable while vend_req is high.
- vend_ack, in, 1: dispenser done.
- chg_req, out, 1: request release of one 5c coin.
- chg_ack, in, 1: one 5c coin released.
- credit, out, CREDIT_W: current credit in 5c units.
- busy, out, 1: high in VEND or CHANGE.
- coin_reject, out, 1: one-cycle pulse, coin not credited.
- sel_nak, out, 1: one-cycle pulse, selection refused.

Behaviour:
- Reset (async, rst_n low): state=IDLE; credit, vend_req, vend_id, chg_req, busy, coin_reject, sel_nak all 0. Credit held when reset hits mid-transaction is discarded, not refunded.
- All outputs are registered. Responses appear on the cycle after the sampling edge.
- Coin value per cycle: add = coin_5*1 + coin_10*2.

States:
- IDLE
  - Nonzero add -> credit=add, go to CREDIT.
  - sel_valid -> sel_nak.
  - cancel -> ignored.
- CREDIT. Priority is cancel > sel > coin.
  - cancel -> CHANGE. Any coin in the same cycle is credited first, so the refund includes it.
  - sel_valid with sel_id >= NUM_ITEMS, or price[sel_id] > credit -> sel_nak, stay in CREDIT.
  - sel_valid with price[sel_id] <= credit -> credit = credit - price + add, latch vend_id, go to VEND. Coin accepted in the same cycle.
  - Coin only: if credit + add > MAX_CREDIT -> coin_reject, credit unchanged (whole add rejected). Otherwise credit += add.
  - Credit reaching 0 after a vend returns the FSM to IDLE via VEND (see below).
- VEND
  - vend_req=1 until vend_ack is sampled high.
  - On ack: vend_req=0 next cycle; go to CHANGE if credit>0, else IDLE.
- CHANGE
  - chg_req=1.
  - Each cycle with chg_req && chg_ack: credit -= 1.
  - When credit goes 1 -> 0: chg_req=0 next cycle, go to IDLE.
  - chg_ack while chg_req=0 -> ignored.
- Coins in VEND or CHANGE -> coin_reject, no credit. sel_valid in VEND or CHANGE -> sel_nak. cancel in VEND or CHANGE -> ignored.
- busy = (state==VEND || state==CHANGE).
- Arithmetic:
  - Unsigned CREDIT_W throughout.
  - Intermediate sum is CREDIT_W+1 bits, so the overflow compare cannot wrap.
  - MAX_CREDIT < 2**CREDIT_W - 2 is required; elaboration check.
- A price of 0 is legal: it vends with credit unchanged, but only from CREDIT.

Decomposition:
- Package vend_pkg:
  - state enum IDLE/CREDIT/VEND/CHANGE (2-bit).
  - coin value constants COIN5_U=1, COIN10_U=2.
  - default CREDIT_W, MAX_CREDIT.
- Sub-module vend_credit_acc:
  - credit register, saturating-check adder, price subtract, decrement.
  - Controlled by a 2-bit op from the FSM; outputs credit and overflow flag.
- FSM and handshake logic live in vend_txn_ctrl.

Test Plan:
- Basic vend:
  - price_tbl item0=3.
  - coin_10, then coin_5 -> credit=3.
  - sel_id=0 -> vend_req=1, vend_id=0, credit=0.
  - vend_ack after 4 cycles -> IDLE, chg_req never asserted.
- Change return:
  - item1=5. Insert 10c x4 -> credit=8; sel 1 -> credit=3.
  - After vend_ack, chg_req held; exactly 3 chg_ack cycles -> credit 0, IDLE.
  - Also stall chg_ack for 5 cycles mid-sequence -> chg_req stays 1, credit constant.
- Overflow: credit=19, coin_10 -> coin_reject, credit=19; coin_5 -> credit=20.
- Refusal and cancel:
  - credit=2, sel item0 (price 3) -> sel_nak, stay CREDIT.
  - sel_id=3 with NUM_ITEMS=3 -> sel_nak.
  - cancel plus coin_5 in the same cycle -> refund of 3 coins.
- Simultaneous events:
  - coin_5 and coin_10 in one cycle -> +3.
  - Accepted sel with coin_10 in the same cycle -> coin credited after subtraction.
  - coin during VEND -> coin_reject.
- Reset mid-CHANGE: assert rst_n low asynchronously between edges -> all outputs 0 immediately, state IDLE.
